// File: rtl/riscv_ctrl_pkg.sv
// ============================================================================
// riscv_ctrl_pkg: states, opcodes and datapath select encodings for the RV32 core
// Revision: 1.0
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_START   = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEM_ADR = 4'd3,
      S_MEM_RD  = 4'd4,
      S_MEM_WB  = 4'd5,
      S_MEM_WR  = 4'd6,
      S_EXEC_R  = 4'd7,
      S_EXEC_I  = 4'd8,
      S_ALU_WB  = 4'd9,
      S_BEQ     = 4'd10
   } state_e;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT  = 2'b00;
   localparam logic [1:0] RES_MEMDATA = 2'b01;
   localparam logic [1:0] RES_ALU     = 2'b10;

   // An instruction retires on the edge that returns the FSM to FETCH.
   function automatic logic is_retire(input state_e st, input logic ready);
      return (st == S_MEM_WB) || (st == S_ALU_WB) || (st == S_BEQ) ||
             ((st == S_MEM_WR) && ready);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_perf_cnt.sv
// ============================================================================
// ctrl_perf_cnt: free-running cycle counter and retired-instruction counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module ctrl_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             count_en,
   input  logic             retire,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if (count_en) cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (retire)   instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
// ============================================================================
// multicycle_ctrl_fsm: main control FSM of the multicycle RV32 core
// Optional perf counters under macro CTRL_PERF_CNT_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             adr_src,
   output logic             ir_write,
   output logic             pc_write,
   output logic             branch,
   output logic             reg_write,
   output logic [1:0]       alu_op,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       result_src,
   output logic             illegal
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
`endif
);

   state_e state;
   state_e state_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_START;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      reg_write  = 1'b0;
      alu_op     = ALUOP_ADD;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      result_src = RES_ALUOUT;
      illegal    = 1'b0;

      case (state)
         S_START: state_nxt = S_FETCH;

         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            if (mem_ready) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               state_nxt = S_DECODE;
            end
         end

         // The shared ALU precomputes the branch target into ALUOut here.
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (opcode)
               OPC_R:                state_nxt = S_EXEC_R;
               OPC_LOAD, OPC_STORE:  state_nxt = S_MEM_ADR;
               OPC_BRANCH:           state_nxt = S_BEQ;
               OPC_IMM:              state_nxt = S_EXEC_I;
               default: begin
                  illegal   = 1'b1;
                  state_nxt = S_FETCH;
               end
            endcase
         end

         S_MEM_ADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            state_nxt = (opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
         end

         S_MEM_RD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) state_nxt = S_MEM_WB;
         end

         S_MEM_WB: begin
            reg_write  = 1'b1;
            result_src = RES_MEMDATA;
            state_nxt  = S_FETCH;
         end

         S_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) state_nxt = S_FETCH;
         end

         S_EXEC_R: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            alu_op    = ALUOP_FUNCT;
            state_nxt = S_ALU_WB;
         end

         S_EXEC_I: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
            state_nxt = S_ALU_WB;
         end

         S_ALU_WB: begin
            reg_write  = 1'b1;
            result_src = RES_ALUOUT;
            state_nxt  = S_FETCH;
         end

         // The PC takes ALUOut only when the datapath sees zero set.
         S_BEQ: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            alu_op     = ALUOP_SUB;
            branch     = 1'b1;
            result_src = RES_ALUOUT;
            state_nxt  = S_FETCH;
         end

         default: state_nxt = S_START;
      endcase
   end

   // zero gates branch in the datapath, not here.
   logic unused_zero;
   assign unused_zero = zero;

`ifdef CTRL_PERF_CNT_EN
   ctrl_perf_cnt #(
      .CNT_W (CNT_W)
   ) u_perf_cnt (
      .clk       (clk),
      .reset     (reset),
      .count_en  (state != S_START),
      .retire    (is_retire(state, mem_ready)),
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt)
   );
`else
   logic unused_cnt_w;
   assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

`default_nettype wire
